// File: rtl/linear_proj_pkg.sv
// Shared types and sizes for the linear-projection datapath.
//   OUT_WORD_W     : width of one matmul result lane
//   TOTAL_INPUT_W  : result lanes presented per acc_done_wrap capture
//   res_wr_state_t : state encoding of the result-BRAM writer
package linear_proj_pkg;

    localparam int WIDTH_OUT     = 16;
    localparam int CHUNK_SIZE    = 1;
    localparam int NUM_CORES_A   = 2;
    localparam int NUM_CORES_B   = 1;
    localparam int TOTAL_MODULES = 1;

    localparam int OUT_WORD_W    = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES;
    localparam int TOTAL_INPUT_W = 4;

    typedef enum logic [1:0] {
        RW_IDLE,
        RW_ARMED,
        RW_WRITE,
        RW_DONE
    } res_wr_state_t;

endpackage

// File: rtl/result_hold_buf.sv
// Two-entry lane buffer (hold + pending) in front of the result BRAM writer.
// The hold entry is the capture currently being written out; the pending entry
// absorbs one capture that arrives while the hold entry is still draining.
// Ports:
//   clk, rst_n    : clock, async active-low reset (both entries invalid)
//   cap_req_i     : capture strobe, already qualified by the writer state
//   cap_allow_i   : capture-count limit not yet reached
//   pop_i         : hold entry fully written (final-word cycle)
//   lanes_i       : result lanes to capture
//   rd_idx_i      : lane index read from the hold entry
//   rd_word_o     : hold[rd_idx_i]
//   accept_o      : capture taken this cycle
//   drop_o        : capture lost because both entries are occupied
//   pend_valid_o  : pending entry holds a capture
module result_hold_buf #(
    parameter int WORD_W = 32,
    parameter int LANES  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_req_i,
    input  logic              cap_allow_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] lanes_i [LANES],
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_word_o,
    output logic              accept_o,
    output logic              drop_o,
    output logic              pend_valid_o
);

    logic              hold_v_q, hold_v_d;
    logic              pend_v_q, pend_v_d;
    logic              full;
    logic              load_hold_pend, load_hold_in, load_pend_in;
    logic [WORD_W-1:0] hold_q [LANES];
    logic [WORD_W-1:0] pend_q [LANES];

    // A full buffer loses the capture even on the cycle the hold entry drains.
    assign full     = hold_v_q & pend_v_q;
    assign drop_o   = cap_req_i & full;
    assign accept_o = cap_req_i & ~full & cap_allow_i;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        hold_v_d       = hold_v_q;
        pend_v_d       = pend_v_q;
        load_hold_pend = 1'b0;
        load_hold_in   = 1'b0;
        load_pend_in   = 1'b0;
        if (pop_i) begin
            if (pend_v_q) begin
                load_hold_pend = 1'b1;
                pend_v_d       = 1'b0;
            end else begin
                hold_v_d = 1'b0;
            end
        end
        // A capture on the draining cycle with pending empty goes straight to
        // hold, which is the same as passing through pending with no gap.
        if (accept_o) begin
            if (!hold_v_d) begin
                load_hold_in = 1'b1;
                hold_v_d     = 1'b1;
            end else begin
                load_pend_in = 1'b1;
                pend_v_d     = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q <= 1'b0;
            pend_v_q <= 1'b0;
        end else begin
            hold_v_q <= hold_v_d;
            pend_v_q <= pend_v_d;
        end
    end

    // NOTE: lane storage is not reset; the valid flags alone say whether it is meaningful.
    always_ff @(posedge clk) begin
        if (load_hold_pend) begin
            hold_q <= pend_q;
        end else if (load_hold_in) begin
            hold_q <= lanes_i;
        end
        if (load_pend_in) begin
            pend_q <= lanes_i;
        end
    end

    assign rd_word_o    = hold_q[rd_idx_i];
    assign pend_valid_o = pend_v_q;

endmodule

// File: rtl/multwrap_result_writer.sv
// Drains matmul-wrapper results into the result BRAM (port A, write-only).
// Each accepted acc_done_wrap capture of TOTAL_INPUT_W lanes is written one word
// per cycle to consecutive addresses; NUM_CAPTURES captures make one pass.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a pass (ignored while busy)
//   acc_done_wrap       : capture strobe from the matmul wrapper
//   out_multwrap_wbram  : result lanes
//   res_ena/res_wea     : BRAM port A enable / write enable (always equal)
//   res_addra/res_dina  : BRAM port A address / write data
//   busy                : pass in progress (ARMED, WRITE, DONE)
//   done                : one-cycle pulse at the end of a pass
//   overflow            : sticky until next start, a capture was dropped
//   res_last            : final word of the pass (only with RESULT_WRITER_LAST_FLAG_EN)
// Build option: define RESULT_WRITER_LAST_FLAG_EN to add the res_last port.
module multwrap_result_writer
    import linear_proj_pkg::*;
#(
    parameter int OUT_WORD_W     = linear_proj_pkg::OUT_WORD_W,
    parameter int TOTAL_INPUT_W  = linear_proj_pkg::TOTAL_INPUT_W,
    parameter int NUM_CAPTURES   = 16,
    parameter int ADDR_WIDTH_OUT = $clog2(NUM_CAPTURES * TOTAL_INPUT_W),
    parameter int BASE_ADDR      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      acc_done_wrap,
    input  logic [OUT_WORD_W-1:0]     out_multwrap_wbram [TOTAL_INPUT_W],
    output logic                      res_ena,
    output logic                      res_wea,
    output logic [ADDR_WIDTH_OUT-1:0] res_addra,
    output logic [OUT_WORD_W-1:0]     res_dina,
    output logic                      busy,
    output logic                      done,
`ifdef RESULT_WRITER_LAST_FLAG_EN
    output logic                      res_last,
`endif
    output logic                      overflow
);

    localparam int CNT_W = $clog2(NUM_CAPTURES + 1);
    localparam int IDX_W = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1;
    localparam logic [CNT_W-1:0] CAP_MAX  = CNT_W'(NUM_CAPTURES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL_INPUT_W - 1);

    res_wr_state_t             state_q, state_d;
    logic [CNT_W-1:0]          cap_cnt_q, cap_cnt_d;   // captures fully written
    logic [CNT_W-1:0]          acc_cnt_q, acc_cnt_d;   // captures accepted
    logic [IDX_W-1:0]          word_idx_q, word_idx_d;
    logic                      overflow_q, overflow_d;
    logic                      in_write, last_word;
    logic                      cap_req, cap_allow, accept, drop, pend_valid;
    logic [OUT_WORD_W-1:0]     rd_word;
    logic [ADDR_WIDTH_OUT-1:0] addr_calc;

    assign in_write  = (state_q == RW_WRITE);
    assign last_word = in_write && (word_idx_q == IDX_LAST);
    assign cap_req   = acc_done_wrap && ((state_q == RW_ARMED) || in_write);
    assign cap_allow = (acc_cnt_q < CAP_MAX);

    result_hold_buf #(
        .WORD_W (OUT_WORD_W),
        .LANES  (TOTAL_INPUT_W),
        .IDX_W  (IDX_W)
    ) u_hold_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .cap_req_i    (cap_req),
        .cap_allow_i  (cap_allow),
        .pop_i        (last_word),
        .lanes_i      (out_multwrap_wbram),
        .rd_idx_i     (word_idx_q),
        .rd_word_o    (rd_word),
        .accept_o     (accept),
        .drop_o       (drop),
        .pend_valid_o (pend_valid)
    );

    always_comb begin
        state_d    = state_q;
        cap_cnt_d  = cap_cnt_q;
        acc_cnt_d  = accept ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
        word_idx_d = word_idx_q;
        overflow_d = overflow_q | drop;
        unique case (state_q)
            RW_IDLE: begin
                if (start) begin
                    state_d    = RW_ARMED;
                    cap_cnt_d  = '0;
                    acc_cnt_d  = '0;
                    word_idx_d = '0;
                    overflow_d = 1'b0;
                end
            end
            RW_ARMED: begin
                if (accept) begin
                    state_d = RW_WRITE;
                end
            end
            RW_WRITE: begin
                if (last_word) begin
                    word_idx_d = '0;
                    cap_cnt_d  = cap_cnt_q + CNT_W'(1);
                    // Next capture already buffered (or arriving now): no gap cycle.
                    if (pend_valid || accept) begin
                        state_d = RW_WRITE;
                    end else if (cap_cnt_d == CAP_MAX) begin
                        state_d = RW_DONE;
                    end else begin
                        state_d = RW_ARMED;
                    end
                end else begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                end
            end
            RW_DONE: begin
                state_d = RW_IDLE;
            end
            default: begin
                state_d = RW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RW_IDLE;
            cap_cnt_q  <= '0;
            acc_cnt_q  <= '0;
            word_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_cnt_q  <= cap_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            word_idx_q <= word_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Address wraps modulo 2**ADDR_WIDTH_OUT by truncation.
    assign addr_calc = ADDR_WIDTH_OUT'(32'(BASE_ADDR) + 32'(cap_cnt_q) * 32'(TOTAL_INPUT_W)
                                       + 32'(word_idx_q));

    // Port outputs are gated by state so reset forces them all low at once,
    // regardless of the unreset lane storage.
    assign res_ena   = in_write;
    assign res_wea   = in_write;
    assign res_addra = in_write ? addr_calc : '0;
    assign res_dina  = in_write ? rd_word : '0;
    assign busy      = (state_q != RW_IDLE);
    assign done      = (state_q == RW_DONE);
    assign overflow  = overflow_q;

`ifdef RESULT_WRITER_LAST_FLAG_EN
    assign res_last  = last_word && (cap_cnt_q == CAP_MAX - CNT_W'(1));
`endif

endmodule

// File: tb/tb_multwrap_result_writer.sv
// Scoreboard bench for multwrap_result_writer (TOTAL_INPUT_W=4, NUM_CAPTURES=2, BASE_ADDR=0).
// Stimulus pushes the expected write (address, data, cycle, last flag) for each
// capture; a negedge monitor pops and compares whenever res_ena is high.
module tb_multwrap_result_writer;

    localparam int W     = 32;
    localparam int LANES = 4;
    localparam int AW    = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        int            cyc;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          acc_done_wrap;
    logic [W-1:0]  lanes [LANES];
    logic          res_ena, res_wea, busy, done, overflow;
    logic [AW-1:0] res_addra;
    logic [W-1:0]  res_dina;
`ifdef RESULT_WRITER_LAST_FLAG_EN
    logic          res_last;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb [$];

    multwrap_result_writer #(
        .OUT_WORD_W     (W),
        .TOTAL_INPUT_W  (LANES),
        .NUM_CAPTURES   (2),
        .ADDR_WIDTH_OUT (AW),
        .BASE_ADDR      (0)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .acc_done_wrap      (acc_done_wrap),
        .out_multwrap_wbram (lanes),
        .res_ena            (res_ena),
        .res_wea            (res_wea),
        .res_addra          (res_addra),
        .res_dina           (res_dina),
        .busy               (busy),
        .done               (done),
`ifdef RESULT_WRITER_LAST_FLAG_EN
        .res_last           (res_last),
`endif
        .overflow           (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write cycle must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && res_ena) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", {61'd0, res_addra} + 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("write_cycle", 64'(cyc), 64'(e.cyc));
                check("write_addr", 64'(res_addra), 64'(e.addr));
                check("write_data", 64'(res_dina), 64'(e.data));
                check("write_wea", 64'(res_wea), 64'd1);
`ifdef RESULT_WRITER_LAST_FLAG_EN
                check("write_last", 64'(res_last), 64'(e.last));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < LANES; i++) lanes[i] = $urandom;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive one capture in the current cycle and queue its four expected writes.
    task automatic pulse_cap(input logic [W-1:0] base, input int first_cyc, input int cap_idx);
        exp_t e;
        for (int i = 0; i < LANES; i++) begin
            lanes[i] = base + W'(i);
            e.addr   = AW'(cap_idx * LANES + i);
            e.data   = base + W'(i);
            e.cyc    = first_cyc + i;
            e.last   = (cap_idx == 1) && (i == LANES - 1);
            sb.push_back(e);
        end
        acc_done_wrap = 1'b1;
        tick();
        acc_done_wrap = 1'b0;
        scramble();
    endtask

    // A capture strobe that must not produce any write.
    task automatic pulse_ignored();
        scramble();
        acc_done_wrap = 1'b1;
        tick();
        acc_done_wrap = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("done_cycle", 64'(cyc), 64'(exp_cyc));
                check("busy_with_done", 64'(busy), 64'd1);
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("done_pulse_width", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_ena"}, 64'(res_ena), 64'd0);
        check({tag, "_wea"}, 64'(res_wea), 64'd0);
        check({tag, "_addr"}, 64'(res_addra), 64'd0);
        check({tag, "_dina"}, 64'(res_dina), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int k;
        rst_n         = 1'b0;
        start         = 1'b0;
        acc_done_wrap = 1'b0;
        for (int i = 0; i < LANES; i++) lanes[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet_outputs("por");
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a write burst.
        do_start();
        k = cyc;
        pulse_cap(32'hDEAD_0000, k + 1, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet_outputs("mid_reset");
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            check("reset_no_done", 64'(done), 64'd0);
            check("reset_no_write", 64'(res_ena), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single pass with a gap between captures; start while busy mid-pass.
        do_start();
        k = cyc;
        pulse_cap(32'hA000_00A0, k + 1, 0);
        repeat (5) tick();                // cyc = k+6, ARMED with one capture written
        do_start();                       // ignored
        repeat (3) tick();                // cyc = k+10
        pulse_cap(32'hB000_00B0, k + 11, 1);
        wait_done(k + 15);
        check("single_overflow", 64'(overflow), 64'd0);

        // Back-to-back: second capture two cycles into the first burst.
        tick();
        do_start();
        k = cyc;
        pulse_cap(32'h1111_0000, k + 1, 0);
        tick();
        pulse_cap(32'h2222_0000, k + 5, 1);
        wait_done(k + 9);
        check("b2b_overflow", 64'(overflow), 64'd0);

        // Overflow: a third capture while pending is occupied is dropped.
        tick();
        do_start();
        k = cyc;
        pulse_cap(32'h3333_0000, k + 1, 0);
        tick();
        pulse_cap(32'h4444_0000, k + 5, 1);
        pulse_ignored();
        @(negedge clk);
        check("overflow_set", 64'(overflow), 64'd1);
        wait_done(k + 9);
        check("overflow_sticky", 64'(overflow), 64'd1);
        tick();
        do_start();
        @(negedge clk);
        check("overflow_cleared_by_start", 64'(overflow), 64'd0);
        check("armed_busy", 64'(busy), 64'd1);

        // Start while armed is ignored; capture on the final-word cycle follows back-to-back.
        tick();
        do_start();
        k = cyc;
        pulse_cap(32'h5555_0000, k + 1, 0);
        repeat (3) tick();                // cyc = k+4, final word of first burst
        pulse_cap(32'h6666_0000, k + 5, 1);
        wait_done(k + 9);
        check("last_word_cap_overflow", 64'(overflow), 64'd0);

        // Capture strobe in IDLE is ignored.
        tick();
        pulse_ignored();
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_no_write", 64'(res_ena), 64'd0);
        end

        repeat (2) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
